pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_LATENCY, default 32: cycles from multiply/divide issue until HI/LO is readable; legal range 1..63.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 each: source registers of the instruction held in IF/ID.
REQ-005 The block SHALL have port id_uses_rt, input, 1: the ID instruction reads rt.
REQ-006 The block SHALL have port ex_mem_read, input, 1: the ID/EX instruction is a load.
REQ-007 The block SHALL have port ex_rt, input, 5: destination of that load.
REQ-008 The block SHALL have port id_is_mdu, input, 1: the ID instruction is mult/multu/div/divu.
REQ-009 The block SHALL have port id_reads_hilo, input, 1: the ID instruction is mfhi/mflo.
REQ-010 The block SHALL have port id_redirect, input, 1: a jump or taken branch is resolved in ID.
REQ-011 The block SHALL have port pc_write, output, 1: PC update enable.
REQ-012 The block SHALL have port ifid_stall, output, 1: hold IF/ID.
REQ-013 The block SHALL have port ifid_flush, output, 1: load the NOP pattern into IF/ID (drives its jump input).
REQ-014 The block SHALL have port idex_bubble, output, 1: zero the ID/EX control fields.
REQ-015 The block SHALL have port mdu_busy, output, 1: state is MDU_BUSY.
REQ-016 The block SHALL have port stall_cycles, output, 32: count of stalled cycles.

Function
REQ-017 Load-use hazard SHALL be: ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-018 MDU hazard SHALL be: state==MDU_BUSY & (id_reads_hilo | id_is_mdu).
REQ-019 stall SHALL be: load-use hazard | MDU hazard; stall SHALL NOT depend on any registered hazard flag, i.e. it has zero latency.
REQ-020 When stall=1, the outputs SHALL be pc_write=0, ifid_stall=1, idex_bubble=1, ifid_flush=0; otherwise pc_write=1, ifid_stall=0, idex_bubble=0.
REQ-021 ifid_flush SHALL equal id_redirect & !stall; a stalled redirect is suppressed and is re-evaluated next cycle.
REQ-022 The FSM SHALL have two states, RUN and MDU_BUSY, with a 6-bit down-counter cnt.
REQ-023 RUN -> MDU_BUSY SHALL occur when id_is_mdu & !stall & MDU_LATENCY>1; cnt loads MDU_LATENCY-1.
REQ-024 With MDU_LATENCY==1, an MDU issue SHALL stay in RUN with no busy cycles.
REQ-025 In MDU_BUSY, cnt SHALL decrement every cycle; when cnt==1 the next state SHALL be RUN and cnt SHALL become 0.
REQ-026 An issue at cycle t SHALL therefore give MDU_BUSY on cycles t+1..t+N-1 and RUN on cycle t+N, where N=MDU_LATENCY.
REQ-027 An MDU instruction arriving during MDU_BUSY SHALL stall, then issue in the first RUN cycle and reload cnt.
REQ-028 A simultaneous load-use hazard and id_is_mdu in RUN SHALL NOT start MDU_BUSY.
REQ-029 stall_cycles SHALL increment on every cycle with ifid_stall=1 and saturate at 32'hFFFFFFFF.

Reset
REQ-030 While reset=1, the block SHALL go to state RUN with cnt=0 and stall_cycles=0, and SHALL drive pc_write=1, ifid_stall=0, ifid_flush=0, idex_bubble=0, mdu_busy=0, ignoring all hazard inputs.
REQ-031 A reset asserted mid-MDU_BUSY SHALL abort the countdown; the first cycle after reset is RUN.

Structure
REQ-032 The state encoding (RUN=0, MDU_BUSY=1), the zero-register constant 5'd0 and the default MDU latency SHALL live in the shared pipeline package.
REQ-033 The countdown SHALL be one sub-module, hazard_mdu_timer, taking load, load value and tick, and returning busy and done.
REQ-034 The hazard compare logic SHALL remain inline.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> that cycle pc_write=0, ifid_stall=1, idex_bubble=1; next cycle, with ex_mem_read=0, all return to normal; stall_cycles=1.
REQ-036 Register-zero: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
REQ-037 MDU: MDU_LATENCY=4, id_is_mdu at t, then id_reads_hilo held -> mdu_busy=1 and stall=1 on t+1..t+3; no stall at t+4; stall_cycles=3.
REQ-038 Redirect vs stall: id_redirect=1 with a load-use hazard at the same cycle -> ifid_flush=0; next cycle, hazard gone -> ifid_flush=1 for exactly one cycle.
REQ-039 Reset mid-op: MDU_LATENCY=32, reset pulsed at busy cycle 10 -> next cycle state RUN, mdu_busy=0, stall_cycles=0.
REQ-040 Back-to-back MDU: a second id_is_mdu at t+2 with N=4 -> stall on t+2..t+3; reissue at t+4; busy on t+5..t+7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-zero constant,
// default multiply/divide latency and the countdown width.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         DEFAULT_MDU_LATENCY = 32;
    localparam int         CNT_W               = 6;
    localparam logic [31:0] STALL_CNT_MAX      = 32'hFFFF_FFFF;

    // Saturating increment for the performance counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == STALL_CNT_MAX) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_timer.sv
// Down-counter that tracks how long HI/LO stays unreadable after an MDU issue.
module hazard_mdu_timer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] cnt;

    // A load wins over a tick so a reissue restarts the countdown cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
    assign done = (cnt == W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard controller: load-use and HI/LO interlocks, redirect flush
// arbitration and a stalled-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = DEFAULT_MDU_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        id_is_mdu,
    input  logic        id_reads_hilo,
    input  logic        id_redirect,
    output logic        pc_write,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] LOAD_VAL    = CNT_W'(MDU_LATENCY - 1);
    localparam logic             MULTI_CYCLE = (MDU_LATENCY > 1);

    hz_state_e state, state_nxt;
    logic      load_use;
    logic      mdu_hazard;
    logic      stall;
    logic      issue;
    logic      timer_busy;
    logic      timer_done;

    // Hazards are purely combinational so the stall lands in the same cycle.
    always_comb begin
        load_use   = ex_mem_read && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        mdu_hazard = (state == MDU_BUSY) && (id_reads_hilo || id_is_mdu);
        stall      = !reset && (load_use || mdu_hazard);
        issue      = !reset && (state == RUN) && id_is_mdu && !stall && MULTI_CYCLE;
    end

    hazard_mdu_timer #(
        .W (CNT_W)
    ) u_mdu_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (issue),
        .load_val (LOAD_VAL),
        .tick     (state == MDU_BUSY),
        .busy     (timer_busy),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b1;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;

        case (state)
            RUN:      if (issue) state_nxt = MDU_BUSY;
            // An idle timer while busy can only mean a lost load; fall back to RUN.
            MDU_BUSY: if (timer_done || !timer_busy) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase

        if (stall) begin
            pc_write    = 1'b0;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end

        // A stalled redirect is dropped here and re-presented by ID next cycle.
        ifid_flush = !reset && id_redirect && !stall;
    end

    assign mdu_busy = !reset && (state == MDU_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (ifid_stall) begin
            stall_cycles <= sat_inc32(stall_cycles);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three latencies (4, 32, 1) side by side,
// directed scenarios plus random traffic against a cycle-timeline model.
module tb_pipeline_hazard_ctrl;

    localparam int LATS [3] = '{4, 32, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 0, ex_mem_read = 0, id_is_mdu = 0;
    logic       id_reads_hilo = 0, id_redirect = 0;

    logic [2:0]  pcw, stl, fl, bub, bsy;
    logic [31:0] sc [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MDU_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_is_mdu(id_is_mdu),
        .id_reads_hilo(id_reads_hilo), .id_redirect(id_redirect),
        .pc_write(pcw[0]), .ifid_stall(stl[0]), .ifid_flush(fl[0]),
        .idex_bubble(bub[0]), .mdu_busy(bsy[0]), .stall_cycles(sc[0]));

    pipeline_hazard_ctrl #(.MDU_LATENCY(32)) dut32 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_is_mdu(id_is_mdu),
        .id_reads_hilo(id_reads_hilo), .id_redirect(id_redirect),
        .pc_write(pcw[1]), .ifid_stall(stl[1]), .ifid_flush(fl[1]),
        .idex_bubble(bub[1]), .mdu_busy(bsy[1]), .stall_cycles(sc[1]));

    pipeline_hazard_ctrl #(.MDU_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_is_mdu(id_is_mdu),
        .id_reads_hilo(id_reads_hilo), .id_redirect(id_redirect),
        .pc_write(pcw[2]), .ifid_stall(stl[2]), .ifid_flush(fl[2]),
        .idex_bubble(bub[2]), .mdu_busy(bsy[2]), .stall_cycles(sc[2]));

    // Model: HI/LO of an issue at cycle t becomes readable at cycle t+N;
    // anything before that is a busy cycle. ready[k] holds that cycle number.
    longint      cyc = 0;
    longint      ready [3] = '{0, 0, 0};
    logic [31:0] scm [3] = '{0, 0, 0};

    function automatic logic m_loaduse();
        return ex_mem_read && ex_rt != 5'd0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    function automatic logic m_busy(input longint r);
        return !reset && cyc < r;
    endfunction

    function automatic logic m_stall(input longint r);
        return !reset && (m_loaduse() || (cyc < r && (id_reads_hilo || id_is_mdu)));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                ready[k] <= 0;
                scm[k]   <= 0;
            end else if (m_stall(ready[k])) begin
                if (scm[k] != 32'hFFFF_FFFF) scm[k] <= scm[k] + 1;
            end else if (id_is_mdu) begin
                ready[k] <= cyc + LATS[k];
            end
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_mem_read = 0;
        id_is_mdu = 0; id_reads_hilo = 0; id_redirect = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_is_mdu = 1; id_reads_hilo = 1; id_redirect = 1;
        tick();
        #3;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({pcw[k], stl[k], fl[k], bub[k], bsy[k]} !== 5'b10000) begin
                failures++;
                $display("FAIL reset_outputs k=%0d got=%b exp=10000", k, {pcw[k], stl[k], fl[k], bub[k], bsy[k]});
            end
            checks++;
            if (sc[k] !== 32'd0) begin
                failures++;
                $display("FAIL reset_stall_cycles k=%0d got=%0d exp=0", k, sc[k]);
            end
        end
        tick();
        reset = 0; idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8;
        #3;
        checks++;
        if ({pcw[0], stl[0], bub[0], fl[0]} !== 4'b0110) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=0110", {pcw[0], stl[0], bub[0], fl[0]});
        end
        tick();
        ex_mem_read = 0;
        #3;
        checks++;
        if ({pcw[0], stl[0], bub[0]} !== 3'b100) begin
            failures++;
            $display("FAIL load_use_release got=%b exp=100", {pcw[0], stl[0], bub[0]});
        end
        checks++;
        if (sc[0] !== 32'd1) begin
            failures++;
            $display("FAIL load_use_count got=%0d exp=1", sc[0]);
        end
        tick();
        // rt path only counts when the ID instruction actually reads rt
        id_rs = 3; id_rt = 9; ex_rt = 9; ex_mem_read = 1; id_uses_rt = 0;
        #3;
        checks++;
        if (stl[0] !== 1'b0) begin
            failures++;
            $display("FAIL rt_unused got=%b exp=0", stl[0]);
        end
        tick();
        id_uses_rt = 1;
        #3;
        checks++;
        if (stl[0] !== 1'b1) begin
            failures++;
            $display("FAIL rt_used got=%b exp=1", stl[0]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reg_zero();
        do_reset();
        ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
        #3;
        checks++;
        if ({pcw[0], stl[0], bub[0]} !== 3'b100) begin
            failures++;
            $display("FAIL reg_zero got=%b exp=100", {pcw[0], stl[0], bub[0]});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mdu();
        do_reset();
        id_is_mdu = 1;
        #3;
        checks++;
        if ({stl[0], bsy[0]} !== 2'b00) begin
            failures++;
            $display("FAIL mdu_issue got=%b exp=00", {stl[0], bsy[0]});
        end
        tick();
        id_is_mdu = 0; id_reads_hilo = 1;
        for (int i = 1; i <= 3; i++) begin
            #3;
            checks++;
            if ({bsy[0], stl[0], pcw[0]} !== 3'b110) begin
                failures++;
                $display("FAIL mdu_busy_t%0d got=%b exp=110", i, {bsy[0], stl[0], pcw[0]});
            end
            tick();
        end
        #3;
        checks++;
        if ({bsy[0], stl[0]} !== 2'b00) begin
            failures++;
            $display("FAIL mdu_done got=%b exp=00", {bsy[0], stl[0]});
        end
        checks++;
        if (sc[0] !== 32'd3) begin
            failures++;
            $display("FAIL mdu_count got=%0d exp=3", sc[0]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_redirect = 1;
        #3;
        checks++;
        if ({fl[0], stl[0]} !== 2'b01) begin
            failures++;
            $display("FAIL redirect_stalled got=%b exp=01", {fl[0], stl[0]});
        end
        tick();
        ex_mem_read = 0;
        #3;
        checks++;
        if (fl[0] !== 1'b1) begin
            failures++;
            $display("FAIL redirect_taken got=%b exp=1", fl[0]);
        end
        tick();
        id_redirect = 0;
        #3;
        checks++;
        if (fl[0] !== 1'b0) begin
            failures++;
            $display("FAIL redirect_once got=%b exp=0", fl[0]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        id_is_mdu = 1;
        tick();
        id_is_mdu = 0; id_reads_hilo = 1;
        for (int i = 1; i < 10; i++) tick();
        #3;
        checks++;
        if ({bsy[1], stl[1]} !== 2'b11) begin
            failures++;
            $display("FAIL midop_busy got=%b exp=11", {bsy[1], stl[1]});
        end
        tick();
        reset = 1;
        #3;
        checks++;
        if ({pcw[1], stl[1], bsy[1]} !== 3'b100) begin
            failures++;
            $display("FAIL midop_in_reset got=%b exp=100", {pcw[1], stl[1], bsy[1]});
        end
        tick();
        reset = 0;
        #3;
        checks++;
        if ({bsy[1], stl[1]} !== 2'b00) begin
            failures++;
            $display("FAIL midop_after got=%b exp=00", {bsy[1], stl[1]});
        end
        checks++;
        if (sc[1] !== 32'd0) begin
            failures++;
            $display("FAIL midop_count got=%0d exp=0", sc[1]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_bs [9];
        logic [1:0] got;
        // {busy, stall} for dut4 on cycles t..t+8
        exp_bs = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            id_is_mdu = (c == 0 || c == 2 || c == 3 || c == 4);
            #3;
            got = {bsy[0], stl[0]};
            checks++;
            if (got !== exp_bs[c]) begin
                failures++;
                $display("FAIL b2b_t%0d got=%b exp=%b", c, got, exp_bs[c]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_latency1();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            id_is_mdu = 1; id_reads_hilo = c[0];
            #3;
            checks++;
            if ({bsy[2], stl[2]} !== 2'b00) begin
                failures++;
                $display("FAIL lat1_t%0d got=%b exp=00", c, {bsy[2], stl[2]});
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic s;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            reset         = ($urandom_range(0, 63) == 0);
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_rt         = 5'($urandom_range(0, 3));
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom);
            id_is_mdu     = ($urandom_range(0, 5) == 0);
            id_reads_hilo = ($urandom_range(0, 2) == 0);
            id_redirect   = ($urandom_range(0, 3) == 0);
            #3;
            for (int k = 0; k < 3; k++) begin
                s = m_stall(ready[k]);
                checks++;
                if ({pcw[k], stl[k], bub[k]} !== {!s, s, s}) begin
                    failures++;
                    $display("FAIL rand_stall k=%0d cyc=%0d got=%b exp=%b", k, cyc, {pcw[k], stl[k], bub[k]}, {!s, s, s});
                end
                checks++;
                if (fl[k] !== (!reset && id_redirect && !s)) begin
                    failures++;
                    $display("FAIL rand_flush k=%0d cyc=%0d got=%b exp=%b", k, cyc, fl[k], !reset && id_redirect && !s);
                end
                checks++;
                if (bsy[k] !== m_busy(ready[k])) begin
                    failures++;
                    $display("FAIL rand_busy k=%0d cyc=%0d got=%b exp=%b", k, cyc, bsy[k], m_busy(ready[k]));
                end
                checks++;
                if (sc[k] !== scm[k]) begin
                    failures++;
                    $display("FAIL rand_count k=%0d cyc=%0d got=%0d exp=%0d", k, cyc, sc[k], scm[k]);
                end
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        tick();
        test_reset();
        test_load_use();
        test_reg_zero();
        test_mdu();
        test_redirect();
        test_reset_mid_op();
        test_back_to_back();
        test_latency1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
